store_queue_ctrl: RTL

Store queue controller. It sits between the MEM-stage store byte-lane alignment logic and the data-memory port. It accepts aligned stores (active-low byte write enables plus lane-positioned data) and buffers them in a small FIFO. It merges back-to-back stores to the same word, drains them to memory over a req/ack handshake, and flags loads that hit a pending store so the pipeline can stall.

---
 rtl/store_queue_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/store_queue_ctrl.sv
// store_queue_ctrl
//   Buffers aligned MEM-stage stores in a small FIFO and drains them to the
//   data-memory port one word at a time over a req/ack handshake. Back-to-back
//   stores to the word at the tail are merged when that entry has not yet been
//   presented to memory. Loads that hit any pending word raise ld_hazard.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   st_valid/st_addr  store request, byte address ([1:0] ignored)
//   st_web/st_wdata   active-low byte enables and lane-aligned data
//   st_ready          store is taken at this edge when st_valid is high
//   ld_valid/ld_addr  load probe; ld_hazard flags a pending store to that word
//   dm_req/dm_addr    registered write request to memory, word-aligned address
//   dm_web/dm_wdata   registered enables and data of the head entry
//   dm_ack            memory took the head write this cycle
//   empty             nothing queued and no write in flight

module store_queue_ctrl #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [3:0]        st_web,
  input  logic [31:0]       st_wdata,
  output logic              st_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_hazard,
  output logic              dm_req,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [3:0]        dm_web,
  output logic [31:0]       dm_wdata,
  input  logic              dm_ack,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int WA_W  = ADDR_W - 2;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  logic              r_valid [DEPTH];
  logic [WA_W-1:0]   r_addr  [DEPTH];
  logic [3:0]        r_web   [DEPTH];
  logic [31:0]       r_wdata [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;
  state_t            r_state;

  logic [PTR_W-1:0]  w_lastIdx;
  logic              w_nullStore;
  logic              w_tailLocked;
  logic              w_mergeHit;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W:0]    w_countNext;
  logic [3:0]        w_mergedWeb;
  logic [31:0]       w_mergedData;
  logic [PTR_W-1:0]  w_nextHeadIdx;
  logic [WA_W-1:0]   w_nextAddr;
  logic [3:0]        w_nextWeb;
  logic [31:0]       w_nextData;
  logic              w_ldHit;
  logic              w_unused;

  assign w_unused = ^{st_addr[1:0], ld_addr[1:0]};

  // The tail entry is the most recently pushed one; it is locked against
  // merging only while it is also the head being presented to memory.
  assign w_lastIdx    = r_tail - PTR_W'(1);
  assign w_nullStore  = (st_web == 4'b1111);
  assign w_tailLocked = (w_lastIdx == r_head) && (r_state == S_BUSY);
  assign w_mergeHit   = st_valid && !w_nullStore && (r_count != '0) &&
                        (r_addr[w_lastIdx] == st_addr[ADDR_W-1:2]) && !w_tailLocked;

  assign st_ready    = (r_count < FULL_CNT) || w_mergeHit;
  assign w_push      = st_valid && st_ready && !w_nullStore && !w_mergeHit;
  assign w_pop       = (r_state == S_BUSY) && dm_ack;
  assign w_countNext = r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};

  assign empty = (r_count == '0) && (r_state == S_IDLE);

  // Byte-wise merge of the incoming store over the tail entry.
  always_comb begin
    w_mergedWeb  = r_web[w_lastIdx] & st_web;
    w_mergedData = r_wdata[w_lastIdx];
    for (int b = 0; b < 4; b++) begin
      if (!st_web[b]) begin
        w_mergedData[8*b +: 8] = st_wdata[8*b +: 8];
      end
    end
  end

  // Contents the head will hold after this edge, so dm_* can be loaded in the
  // same edge that pushes or merges into the entry about to be presented.
  always_comb begin
    w_nextHeadIdx = w_pop ? (r_head + PTR_W'(1)) : r_head;
    if (w_push && (w_nextHeadIdx == r_tail)) begin
      w_nextAddr = st_addr[ADDR_W-1:2];
      w_nextWeb  = st_web;
      w_nextData = st_wdata;
    end else if (w_mergeHit && (w_nextHeadIdx == w_lastIdx)) begin
      w_nextAddr = r_addr[w_lastIdx];
      w_nextWeb  = w_mergedWeb;
      w_nextData = w_mergedData;
    end else begin
      w_nextAddr = r_addr[w_nextHeadIdx];
      w_nextWeb  = r_web[w_nextHeadIdx];
      w_nextData = r_wdata[w_nextHeadIdx];
    end
  end

  // Load hazard covers every valid entry, including the one in flight.
  always_comb begin
    w_ldHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_addr[i] == ld_addr[ADDR_W-1:2])) begin
        w_ldHit = 1'b1;
      end
    end
  end

  assign ld_hazard = ld_valid && w_ldHit;

  // Entry storage: push into the tail slot, merge into the last entry,
  // invalidate the head when memory acknowledges it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_addr[i]  <= '0;
        r_web[i]   <= 4'b1111;
        r_wdata[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_addr[r_tail]  <= st_addr[ADDR_W-1:2];
        r_web[r_tail]   <= st_web;
        r_wdata[r_tail] <= st_wdata;
      end
      if (w_mergeHit) begin
        r_web[w_lastIdx]   <= w_mergedWeb;
        r_wdata[w_lastIdx] <= w_mergedData;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
      end
    end
  end

  // Drain FSM with pointer bookkeeping; dm_* are loaded whenever a new head
  // is about to be presented and held unchanged until dm_ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      dm_req   <= 1'b0;
      dm_addr  <= '0;
      dm_web   <= 4'b1111;
      dm_wdata <= '0;
    end else begin
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      r_count <= w_countNext;

      case (r_state)
        S_IDLE: begin
          if (w_countNext != '0) begin
            r_state  <= S_BUSY;
            dm_req   <= 1'b1;
            dm_addr  <= {w_nextAddr, 2'b00};
            dm_web   <= w_nextWeb;
            dm_wdata <= w_nextData;
          end
        end
        S_BUSY: begin
          if (w_pop) begin
            if (w_countNext != '0) begin
              dm_addr  <= {w_nextAddr, 2'b00};
              dm_web   <= w_nextWeb;
              dm_wdata <= w_nextData;
            end else begin
              r_state  <= S_IDLE;
              dm_req   <= 1'b0;
              dm_addr  <= '0;
              dm_web   <= 4'b1111;
              dm_wdata <= '0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          dm_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule
